// File: rtl/controle_decripta.sv
// Iterative AES-128 decryption controller: one inverse round per clock over a
// single 128-bit state register, with round keys fetched from an external store.
module controle_decripta #(
    parameter int NUM_RODADAS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inicia,
    input  logic [127:0] texto_cifrado,
    input  logic [127:0] chave_rodada,
    output logic [3:0]   indice_chave,
    output logic         ocupado,
    output logic         pronto,
    output logic [127:0] saida
);

    typedef enum logic [1:0] {
        OCIOSO,
        RODADA,
        FINAL
    } fase_t;

    fase_t        fase, fase_prox;
    logic [3:0]   rodada, rodada_prox;
    logic [127:0] estado, estado_prox;
    logic [127:0] saida_prox;
    logic         pronto_prox;
    logic [127:0] parcial;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse affine map followed by the field inverse, computed as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
        b = b ^ 8'h05;
        r = 8'h01;
        p = b;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Shared by the middle rounds and the final round; only the middle rounds mix.
    assign parcial = inv_sub_bytes(inv_shift_rows(estado)) ^ chave_rodada;
    assign ocupado = (fase != OCIOSO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fase   <= OCIOSO;
            rodada <= 4'd0;
            estado <= '0;
            saida  <= '0;
            pronto <= 1'b0;
        end else begin
            fase   <= fase_prox;
            rodada <= rodada_prox;
            estado <= estado_prox;
            saida  <= saida_prox;
            pronto <= pronto_prox;
        end
    end

    always_comb begin
        fase_prox    = fase;
        rodada_prox  = rodada;
        estado_prox  = estado;
        saida_prox   = saida;
        pronto_prox  = 1'b0;
        indice_chave = 4'(NUM_RODADAS);
        case (fase)
            OCIOSO: begin
                if (inicia) begin
                    estado_prox = texto_cifrado ^ chave_rodada;
                    rodada_prox = 4'(NUM_RODADAS - 1);
                    fase_prox   = RODADA;
                end
            end
            RODADA: begin
                indice_chave = rodada;
                estado_prox  = inv_mix_columns(parcial);
                if (rodada == 4'd1)
                    fase_prox = FINAL;
                else
                    rodada_prox = rodada - 4'd1;
            end
            FINAL: begin
                indice_chave = 4'd0;
                saida_prox   = parcial;
                pronto_prox  = 1'b1;
                fase_prox    = OCIOSO;
            end
            default: fase_prox = OCIOSO;
        endcase
    end

endmodule
